lcd_fb_arbiter: RTL
===================

LCD_FB_ARBITER -- requirements
Module: lcd_fb_arbiter

Interface
REQ-001 Parameter ADDR_W, default 17, framebuffer word address width (480x272 pixels).
REQ-002 Parameter DATA_W, default 16, pixel width (RGB565).
REQ-003 Parameter STARVE_LIM, default 8, number of host wait cycles before the host is forced a slot.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 disp_req, disp_addr  in  1, ADDR_W  scanout read request and address, held until granted.
REQ-007 disp_gnt, disp_rvld, disp_rdata  out  1, 1, DATA_W  scanout grant pulse, read-data valid, read data.
REQ-008 host_req, host_we, host_addr, host_wdata  in  1, 1, ADDR_W, DATA_W  host request, write enable, address, write data, held until granted.
REQ-009 host_gnt, host_rvld, host_rdata  out  1, 1, DATA_W  host grant pulse, read-data valid, read data.
REQ-010 mem_cs, mem_we, mem_addr, mem_wdata  out  1, 1, ADDR_W, DATA_W  single-port SRAM command.
REQ-011 mem_rdata  in  DATA_W  SRAM read data, valid exactly 1 cycle after a read command.

Function
REQ-012 FSM states: IDLE, DISP, HOST, TURN; exactly one state active at a time.
REQ-013 Requests are sampled in cycle N; the winner's mem_cs, mem_addr and gnt pulse are registered and appear in cycle N+1.
REQ-014 Each grant issues exactly one 1-cycle memory access; back-to-back grants to one requester are allowed every cycle.
REQ-015 Read data is presented in cycle N+2 with the winner's rvld high for 1 cycle; the other requester's rvld stays low.
REQ-016 Display has fixed priority over host when both request, except as stated in REQ-017.
REQ-017 starve_cnt increments each cycle host_req=1 and host is not granted; when starve_cnt=STARVE_LIM-1, the host wins the next arbitration even if disp_req=1.
REQ-018 starve_cnt clears on any host grant or when host_req=0; its width is $clog2(STARVE_LIM)+1 and it saturates without wrapping.
REQ-019 After a host write (HOST with mem_we=1), the FSM enters TURN for 1 cycle with mem_cs=0, then arbitrates; requests in TURN are deferred, not lost.
REQ-020 A host read does not trigger TURN.
REQ-021 In IDLE with no request: mem_cs=0 and mem_we=0; mem_addr and mem_wdata hold their last value.
REQ-022 The two gnt outputs are never both high; mem_we is high only with mem_cs and only for host writes.
REQ-023 A request that deasserts before its grant is dropped without issuing a memory access.

Reset
REQ-024 Asserting rst_n low, at any time including mid-access, forces state IDLE, all gnt/rvld/mem_cs/mem_we low, starve_cnt=0, and mem_addr/mem_wdata/rdata to 0.
REQ-025 A read in flight at reset produces no rvld after reset is released.
REQ-026 The first grant can occur in the 2nd cycle after rst_n rises.

Configuration
REQ-027 With LCD_FB_ARB_STATS_EN defined, the block adds outputs stat_conflicts[15:0] and stat_forced[15:0].
REQ-028 stat_conflicts counts cycles with both requests pending; stat_forced counts starvation-forced host grants; both saturate at 0xFFFF and clear on reset.
REQ-029 Without LCD_FB_ARB_STATS_EN, these ports and counters do not exist and behaviour is otherwise identical.

Structure
REQ-030 Package lcd_pkg holds the FSM state enum and the display geometry constants (480, 272, 256, 45).
REQ-031 Sub-module lcd_fb_starve_ctr implements the starvation counter and force flag; the rest is flat.

Verification
REQ-032 Only disp_req=1 with addr 0..3, held 4 cycles -> disp_gnt high for 4 consecutive cycles, mem_addr 0,1,2,3, disp_rvld with data 2 cycles after each request.
REQ-033 Host write to addr 0x100 with data 0xF800, followed by a host read of 0x100 -> 1 TURN cycle with mem_cs=0, then the read returns host_rdata=0xF800.
REQ-034 disp_req and host_req held continuously with STARVE_LIM=8 -> host_gnt once every 9th grant, display receives the other 8.
REQ-035 rst_n pulsed low the cycle after a read grant -> no rvld after release; all outputs 0.
REQ-036 host_req dropped after 2 cycles without a grant -> no host memory access, starve_cnt returns to 0.
REQ-037 With LCD_FB_ARB_STATS_EN, 10 cycles of both requests pending -> stat_conflicts=10 and stat_forced=1.

Source files
------------

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared FSM state type and display geometry for the framebuffer arbiter
package lcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DISP,
    ST_HOST,
    ST_TURN
  } arb_state_e;

  // 480x272 RGB565 panel; the scanout engine fetches in 256-word bursts with 45 blanking clocks per line
  localparam int LCD_H_ACTIVE   = 480;
  localparam int LCD_V_ACTIVE   = 272;
  localparam int LCD_SCAN_BURST = 256;
  localparam int LCD_H_BLANK    = 45;

  // Linear word address of pixel (x, y) in the framebuffer
  function automatic logic [16:0] pix_addr(input logic [8:0] x, input logic [8:0] y);
    return 17'(y) * 17'(LCD_H_ACTIVE) + 17'(x);
  endfunction

endpackage

// File: rtl/lcd_fb_arbiter_if.sv
// rtl/lcd_fb_arbiter_if.sv - requester and SRAM signal bundle around the framebuffer arbiter
interface lcd_fb_arbiter_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 16
);
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_gnt;
  logic              disp_rvld;
  logic [DATA_W-1:0] disp_rdata;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic              host_rvld;
  logic [DATA_W-1:0] host_rdata;

  logic              mem_cs;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  disp_req, disp_addr, host_req, host_we, host_addr, host_wdata, mem_rdata,
    output disp_gnt, disp_rvld, disp_rdata, host_gnt, host_rvld, host_rdata,
    output mem_cs, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output disp_req, disp_addr, host_req, host_we, host_addr, host_wdata, mem_rdata,
    input  disp_gnt, disp_rvld, disp_rdata, host_gnt, host_rvld, host_rdata,
    input  mem_cs, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lcd_fb_starve_ctr.sv
// rtl/lcd_fb_starve_ctr.sv - counts host wait cycles and raises the force flag once the host has waited long enough
module lcd_fb_starve_ctr #(
  parameter int STARVE_LIM = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_host_req,
  input  logic i_host_win,
  output logic o_force
);
  localparam int CNT_W = $clog2(STARVE_LIM) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(STARVE_LIM);

  logic [CNT_W-1:0] r_starve_cnt;

  // Saturating count of consecutive cycles the host asked and lost; any win or idle host clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (!i_host_req || i_host_win) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt != CNT_MAX) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  // Count reaches the limit on the cycle after it showed LIM-1, so that arbitration goes to the host
  assign o_force = i_host_req && (r_starve_cnt >= CNT_LIM);

endmodule

// File: rtl/lcd_fb_arbiter.sv
// rtl/lcd_fb_arbiter.sv - scanout/host arbiter for a single-port framebuffer SRAM; LCD_FB_ARB_STATS_EN adds event counters
module lcd_fb_arbiter
  import lcd_pkg::*;
#(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 16,
  parameter int STARVE_LIM = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  lcd_fb_arbiter_if.slave bus
`ifdef LCD_FB_ARB_STATS_EN
  ,
  output logic [15:0]     stat_conflicts,
  output logic [15:0]     stat_forced
`endif
);

  arb_state_e        r_state;
  logic              r_disp_gnt;
  logic              r_host_gnt;
  logic              r_mem_cs;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_disp_rvld;
  logic              r_host_rvld;

  logic              w_block;
  logic              w_force;
  logic              w_pick_host;
  logic              w_pick_disp;

  // The cycle showing a host write cannot arbitrate, which leaves exactly one dead TURN cycle on the bus
  assign w_block     = (r_state == ST_HOST) && r_mem_we;
  assign w_pick_host = !w_block && bus.host_req && (w_force || !bus.disp_req);
  assign w_pick_disp = !w_block && bus.disp_req && !w_pick_host;

  lcd_fb_starve_ctr #(
    .STARVE_LIM (STARVE_LIM)
  ) u_starve (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_host_req (bus.host_req),
    .i_host_win (w_pick_host),
    .o_force    (w_force)
  );

  // Arbitration FSM: the winner's grant and SRAM command are registered into the next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_disp_gnt  <= 1'b0;
      r_host_gnt  <= 1'b0;
      r_mem_cs    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_disp_gnt <= w_pick_disp;
      r_host_gnt <= w_pick_host;
      r_mem_cs   <= w_pick_disp || w_pick_host;
      r_mem_we   <= w_pick_host && bus.host_we;
      if (w_pick_disp) begin
        r_state    <= ST_DISP;
        r_mem_addr <= bus.disp_addr;
      end else if (w_pick_host) begin
        r_state     <= ST_HOST;
        r_mem_addr  <= bus.host_addr;
        r_mem_wdata <= bus.host_wdata;
      end else if (w_block) begin
        r_state <= ST_TURN;
      end else begin
        r_state <= ST_IDLE;
      end
    end
  end

  // Read-return tag: SRAM data lands one cycle after the command, so flag the owner one cycle late
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp_rvld <= 1'b0;
      r_host_rvld <= 1'b0;
    end else begin
      r_disp_rvld <= r_disp_gnt;
      r_host_rvld <= r_host_gnt && !r_mem_we;
    end
  end

  assign bus.disp_gnt   = r_disp_gnt;
  assign bus.host_gnt   = r_host_gnt;
  assign bus.mem_cs     = r_mem_cs;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.disp_rvld  = r_disp_rvld;
  assign bus.host_rvld  = r_host_rvld;
  assign bus.disp_rdata = r_disp_rvld ? bus.mem_rdata : '0;
  assign bus.host_rdata = r_host_rvld ? bus.mem_rdata : '0;

`ifdef LCD_FB_ARB_STATS_EN
  logic [15:0] r_stat_conflicts;
  logic [15:0] r_stat_forced;

  // Saturating counters: cycles with both sides asking, and host wins that only happened through starvation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_conflicts <= '0;
      r_stat_forced    <= '0;
    end else begin
      if (bus.disp_req && bus.host_req && (r_stat_conflicts != 16'hFFFF)) begin
        r_stat_conflicts <= r_stat_conflicts + 16'd1;
      end
      if (w_pick_host && w_force && bus.disp_req && (r_stat_forced != 16'hFFFF)) begin
        r_stat_forced <= r_stat_forced + 16'd1;
      end
    end
  end

  assign stat_conflicts = r_stat_conflicts;
  assign stat_forced    = r_stat_forced;
`endif

endmodule
